// File: rtl/chirp_cmd_parser_if.sv
// Byte-stream, generator-status and configuration signals of chirp_cmd_parser.
// The slave modport is the parser's view; the master modport is the view of the UART/generator side.
interface chirp_cmd_parser_if #(
  parameter int MAX_SF_WIDTH     = 8,
  parameter int BW_BITWIDTH      = 2,
  parameter int DIVIDER_BITWIDTH = 7
);
  logic [7:0]                  i_rx_data;
  logic                        i_rx_valid;
  logic                        i_done_n;
  logic [MAX_SF_WIDTH-1:0]     o_sf;
  logic [BW_BITWIDTH-1:0]      o_bw;
  logic [DIVIDER_BITWIDTH-1:0] o_div;
  logic                        o_start;
  logic                        o_busy;
  logic                        o_err;
  logic [2:0]                  o_err_code;

  modport slave (
    input  i_rx_data, i_rx_valid, i_done_n,
    output o_sf, o_bw, o_div, o_start, o_busy, o_err, o_err_code
  );

  modport master (
    output i_rx_data, i_rx_valid, i_done_n,
    input  o_sf, o_bw, o_div, o_start, o_busy, o_err, o_err_code
  );
endinterface

// File: rtl/chirp_cmd_parser.sv
// Frame parser (SYNC, CMD, PAYLOAD[, CSUM]) owning the chirp configuration registers and start/busy tracking.
// Define CMD_CHECKSUM_EN to require a trailing CSUM byte equal to CMD ^ PAYLOAD.
module chirp_cmd_parser #(
  parameter int MAX_SF_WIDTH     = 8,
  parameter int BW_BITWIDTH      = 2,
  parameter int DIVIDER_BITWIDTH = 7,
  parameter int TIMEOUT_CYCLES   = 21000,
  parameter int TO_WIDTH         = 15
) (
  input logic               i_clk,
  input logic               i_rst_n,
  chirp_cmd_parser_if.slave bus
);
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_SET_SF  = 8'h01;
  localparam logic [7:0] CMD_SET_BW  = 8'h02;
  localparam logic [7:0] CMD_SET_DIV = 8'h03;
  localparam logic [7:0] CMD_START   = 8'h04;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_UNKNOWN = 3'd2;
  localparam logic [2:0] ERR_RANGE   = 3'd3;
  localparam logic [2:0] ERR_BUSY    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, PAY, CSUM} state_e;

  state_e                      state_q, state_d;
  logic [7:0]                  cmd_q, cmd_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]                  pay_q, pay_d;
`endif
  logic [TO_WIDTH-1:0]         toCnt_q, toCnt_d;
  logic [MAX_SF_WIDTH-1:0]     sf_q, sf_d;
  logic [BW_BITWIDTH-1:0]      bw_q, bw_d;
  logic [DIVIDER_BITWIDTH-1:0] div_q, div_d;
  logic                        start_q, start_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic [2:0]                  errCode_q, errCode_d;

  logic       execFrame;
  logic       csumBad;
  logic       rangeOk;
  logic [7:0] frameCmd;
  logic [7:0] framePay;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
`ifdef CMD_CHECKSUM_EN
      pay_q     <= '0;
`endif
      toCnt_q   <= '0;
      sf_q      <= MAX_SF_WIDTH'(7);
      bw_q      <= '0;
      div_q     <= DIVIDER_BITWIDTH'(1);
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      errCode_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
`ifdef CMD_CHECKSUM_EN
      pay_q     <= pay_d;
`endif
      toCnt_q   <= toCnt_d;
      sf_q      <= sf_d;
      bw_q      <= bw_d;
      div_q     <= div_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
`ifdef CMD_CHECKSUM_EN
    pay_d     = pay_q;
`endif
    toCnt_d   = '0;
    sf_d      = sf_q;
    bw_d      = bw_q;
    div_d     = div_q;
    start_d   = 1'b0;
    busy_d    = busy_q & bus.i_done_n;
    err_d     = 1'b0;
    errCode_d = errCode_q;
    execFrame = 1'b0;
    csumBad   = 1'b0;
    rangeOk   = 1'b1;
    frameCmd  = 8'h00;
    framePay  = 8'h00;

    // An arriving byte always beats an expiring timeout.
    if (state_q != IDLE) begin
      if (bus.i_rx_valid) begin
        toCnt_d = '0;
      end else if (toCnt_q == TO_LAST) begin
        state_d   = IDLE;
        err_d     = 1'b1;
        errCode_d = ERR_TIMEOUT;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) state_d = CMD;
      CMD: begin
        if (bus.i_rx_valid) begin
          cmd_d   = bus.i_rx_data;
          state_d = PAY;
        end
      end
      PAY: begin
        if (bus.i_rx_valid) begin
`ifdef CMD_CHECKSUM_EN
          pay_d   = bus.i_rx_data;
          state_d = CSUM;
`else
          frameCmd  = cmd_q;
          framePay  = bus.i_rx_data;
          execFrame = 1'b1;
          state_d   = IDLE;
`endif
        end
      end
      CSUM: begin
`ifdef CMD_CHECKSUM_EN
        if (bus.i_rx_valid) begin
          frameCmd  = cmd_q;
          framePay  = pay_q;
          csumBad   = bus.i_rx_data != (cmd_q ^ pay_q);
          execFrame = 1'b1;
          state_d   = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    case (frameCmd)
      CMD_SET_SF:  rangeOk = framePay >= 8'd6 && framePay <= 8'd12;
      CMD_SET_BW:  rangeOk = (framePay >> BW_BITWIDTH) == 8'd0;
      CMD_SET_DIV: rangeOk = framePay != 8'd0 && (framePay >> DIVIDER_BITWIDTH) == 8'd0;
      default:     rangeOk = 1'b1;
    endcase

    // Error checks are ordered by precedence; a rejected frame touches no register.
    if (execFrame) begin
      if (csumBad) begin
        err_d     = 1'b1;
        errCode_d = ERR_CSUM;
      end else if (frameCmd < CMD_SET_SF || frameCmd > CMD_START) begin
        err_d     = 1'b1;
        errCode_d = ERR_UNKNOWN;
      end else if (busy_q) begin
        err_d     = 1'b1;
        errCode_d = ERR_BUSY;
      end else if (!rangeOk) begin
        err_d     = 1'b1;
        errCode_d = ERR_RANGE;
      end else begin
        case (frameCmd)
          CMD_SET_SF:  sf_d  = MAX_SF_WIDTH'(framePay);
          CMD_SET_BW:  bw_d  = BW_BITWIDTH'(framePay);
          CMD_SET_DIV: div_d = DIVIDER_BITWIDTH'(framePay);
          default: begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_sf       = sf_q;
  assign bus.o_bw       = bw_q;
  assign bus.o_div      = div_q;
  assign bus.o_start    = start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = errCode_q;
endmodule

// File: tb/tb_chirp_cmd_parser.sv
// Scoreboard bench for chirp_cmd_parser: directed frames queue expected events with their cycle,
// and a monitor compares every start/error pulse and configuration change against the queue.
module tb_chirp_cmd_parser;
  localparam int TIMEOUT = 21000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   lastCyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          cyc;
    logic [22:0] vec;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];

  exp_t        monExp;
  string       monName;
  logic [17:0] monCfg;
  logic [17:0] prevCfg;
  logic [22:0] monAct;

  chirp_cmd_parser_if #(
    .MAX_SF_WIDTH(8), .BW_BITWIDTH(2), .DIVIDER_BITWIDTH(7)
  ) bus ();

  chirp_cmd_parser #(
    .MAX_SF_WIDTH(8), .BW_BITWIDTH(2), .DIVIDER_BITWIDTH(7),
    .TIMEOUT_CYCLES(TIMEOUT), .TO_WIDTH(15)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse or configuration change is an event that must match the queue head.
  always @(negedge clk) begin
    monCfg = {bus.o_sf, bus.o_bw, bus.o_div, bus.o_busy};
    monAct = {bus.o_start, bus.o_err, bus.o_err_code, monCfg};
    if (!rst_n) begin
      prevCfg = monCfg;
    end else if (bus.o_start || bus.o_err || monCfg != prevCfg) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event cycle=%0d actual=%h required=no_event", cyc, monAct);
      end else begin
        monExp  = expQ.pop_front();
        monName = nameQ.pop_front();
        if (monAct !== monExp.vec || cyc != monExp.cyc) begin
          failures++;
          $display("[TB] FAIL %s actual=%h@%0d required=%h@%0d",
                   monName, monAct, cyc, monExp.vec, monExp.cyc);
        end
      end
      prevCfg = monCfg;
    end
  end

  task automatic expectEvent(input string name, input int st, input int er, input int code,
                             input int sf, input int bw, input int dv, input int bz, input int atCyc);
    exp_t e;
    e.cyc = atCyc;
    e.vec = {1'(st), 1'(er), 3'(code), 8'(sf), 2'(bw), 7'(dv), 1'(bz)};
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sf"},       int'(bus.o_sf), 7);
    checkOutput({tag, "_bw"},       int'(bus.o_bw), 0);
    checkOutput({tag, "_div"},      int'(bus.o_div), 1);
    checkOutput({tag, "_start"},    int'(bus.o_start), 0);
    checkOutput({tag, "_busy"},     int'(bus.o_busy), 0);
    checkOutput({tag, "_err"},      int'(bus.o_err), 0);
    checkOutput({tag, "_err_code"}, int'(bus.o_err_code), 0);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic doneLow);
    @(posedge clk);
    #1;
    bus.i_rx_data  = d;
    bus.i_rx_valid = 1'b1;
    if (doneLow) bus.i_done_n = 1'b0;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_done_n   = 1'b1;
    lastCyc        = cyc;
  endtask

  task automatic pulseDone();
    @(posedge clk);
    #1 bus.i_done_n = 1'b0;
    @(posedge clk);
    #1 bus.i_done_n = 1'b1;
    lastCyc = cyc;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] pay, input logic doneLowLast);
    sendByte(8'hA5, 1'b0);
    sendByte(cmd, 1'b0);
`ifdef CMD_CHECKSUM_EN
    sendByte(pay, 1'b0);
    sendByte(cmd ^ pay, doneLowLast);
`else
    sendByte(pay, doneLowLast);
`endif
  endtask

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_done_n   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset_low");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset_released");

    applyStimulus(8'h01, 8'h09, 1'b0);
    expectEvent("set_sf_9", 0, 0, 0, 9, 0, 1, 0, lastCyc);
    applyStimulus(8'h04, 8'h00, 1'b0);
    expectEvent("start_idle", 1, 0, 0, 9, 0, 1, 1, lastCyc);
    applyStimulus(8'h03, 8'h05, 1'b0);
    expectEvent("set_div_busy", 0, 1, 4, 9, 0, 1, 1, lastCyc);
    applyStimulus(8'h04, 8'h00, 1'b0);
    expectEvent("start_busy", 0, 1, 4, 9, 0, 1, 1, lastCyc);
    pulseDone();
    expectEvent("busy_clear", 0, 0, 4, 9, 0, 1, 0, lastCyc);
    pulseDone();

    applyStimulus(8'h01, 8'h0D, 1'b0);
    expectEvent("set_sf_13", 0, 1, 3, 9, 0, 1, 0, lastCyc);
`ifdef CMD_CHECKSUM_EN
    sendByte(8'hA5, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h09, 1'b0);
    sendByte(8'h00, 1'b0);
    expectEvent("bad_csum", 0, 1, 1, 9, 0, 1, 0, lastCyc);
`endif
    applyStimulus(8'h07, 8'h00, 1'b0);
    expectEvent("cmd_07", 0, 1, 2, 9, 0, 1, 0, lastCyc);
    applyStimulus(8'hA5, 8'h00, 1'b0);
    expectEvent("cmd_a5_data", 0, 1, 2, 9, 0, 1, 0, lastCyc);
    applyStimulus(8'h02, 8'hA5, 1'b0);
    expectEvent("set_bw_a5", 0, 1, 3, 9, 0, 1, 0, lastCyc);
    applyStimulus(8'h01, 8'h0C, 1'b0);
    expectEvent("set_sf_12", 0, 0, 3, 12, 0, 1, 0, lastCyc);
    applyStimulus(8'h01, 8'h06, 1'b0);
    expectEvent("set_sf_6", 0, 0, 3, 6, 0, 1, 0, lastCyc);
    applyStimulus(8'h01, 8'h05, 1'b0);
    expectEvent("set_sf_5", 0, 1, 3, 6, 0, 1, 0, lastCyc);
    applyStimulus(8'h03, 8'h00, 1'b0);
    expectEvent("set_div_0", 0, 1, 3, 6, 0, 1, 0, lastCyc);
    applyStimulus(8'h03, 8'h80, 1'b0);
    expectEvent("set_div_80", 0, 1, 3, 6, 0, 1, 0, lastCyc);
    applyStimulus(8'h03, 8'h7F, 1'b0);
    expectEvent("set_div_7f", 0, 0, 3, 6, 0, 127, 0, lastCyc);
    applyStimulus(8'h03, 8'h05, 1'b0);
    expectEvent("set_div_5", 0, 0, 3, 6, 0, 5, 0, lastCyc);
    applyStimulus(8'h02, 8'h03, 1'b0);
    expectEvent("set_bw_3", 0, 0, 3, 6, 3, 5, 0, lastCyc);

    sendByte(8'hA5, 1'b0);
    sendByte(8'h01, 1'b0);
    expectEvent("timeout", 0, 1, 5, 6, 3, 5, 0, lastCyc + TIMEOUT);
    repeat (TIMEOUT + 5) @(posedge clk);

    sendByte(8'h00, 1'b0);
    sendByte(8'hFF, 1'b0);
    sendByte(8'h12, 1'b0);
    applyStimulus(8'h02, 8'h02, 1'b0);
    expectEvent("junk_then_bw_2", 0, 0, 5, 6, 2, 5, 0, lastCyc);

    applyStimulus(8'h04, 8'h00, 1'b0);
    expectEvent("start_2", 1, 0, 5, 6, 2, 5, 1, lastCyc);
    applyStimulus(8'h04, 8'h00, 1'b1);
    expectEvent("start_with_done", 0, 1, 4, 6, 2, 5, 0, lastCyc);
    applyStimulus(8'h04, 8'h00, 1'b0);
    expectEvent("start_3", 1, 0, 4, 6, 2, 5, 1, lastCyc);
    applyStimulus(8'h09, 8'h00, 1'b0);
    expectEvent("unknown_over_busy", 0, 1, 2, 6, 2, 5, 1, lastCyc);
    applyStimulus(8'h01, 8'h0D, 1'b0);
    expectEvent("busy_over_range", 0, 1, 4, 6, 2, 5, 1, lastCyc);
    pulseDone();
    expectEvent("busy_clear_2", 0, 0, 4, 6, 2, 5, 0, lastCyc);

    sendByte(8'hA5, 1'b0);
    sendByte(8'h01, 1'b0);
`ifdef CMD_CHECKSUM_EN
    sendByte(8'h09, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("mid_frame_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef CMD_CHECKSUM_EN
    sendByte(8'h08, 1'b0);
`else
    sendByte(8'h09, 1'b0);
`endif
    repeat (4) @(posedge clk);
    applyStimulus(8'h01, 8'h0A, 1'b0);
    expectEvent("set_sf_10_after_reset", 0, 0, 0, 10, 0, 1, 0, lastCyc);

    repeat (10) @(posedge clk);
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
    checkOutput("pending_events", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
